fifo_pixel_reader: RTL and testbench

Read-side companion of the pixel-to-FIFO write path. It pops 64-bit zero-padded words from a standard (non-FWFT) synchronous FIFO with 1-cycle read latency and unpacks bits [23:0] into a 24-bit pixel stream with valid/ready handshake. It generates start-of-frame and end-of-line markers from column/row counters and feeds the downstream resize/DMA datapath.

---
 rtl/fifo_pixel_reader.sv | 159 +++++++++++++++
 tb/tb_fifo_pixel_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pixel_reader.sv
// fifo_pixel_reader
// -----------------
// Read side of the pixel-to-FIFO path. Pops 64-bit zero-padded words from a
// standard synchronous FIFO with one cycle of read latency. Each word is
// unpacked to a 24-bit {R,G,B} pixel on a valid/ready stream that carries
// start-of-frame and end-of-line markers.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       allows new FIFO reads
//   clr          synchronous flush of buffer, counters and in-flight read
//   empty        FIFO empty flag
//   rd_en        FIFO read strobe (combinational)
//   fifo_dout    FIFO read data, valid the cycle after rd_en
//   m_data       pixel out = buffered word[23:0]
//   m_valid      pixel valid
//   m_ready      downstream accept
//   m_sof        first pixel of frame, qualified by m_valid
//   m_eol        last pixel of line, qualified by m_valid
//   frame_done   one-cycle pulse after the last pixel of a frame is taken
//   pad_err      sticky flag: a captured word had nonzero bits [63:24]
module fifo_pixel_reader #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clr,
  input  logic        empty,
  output logic        rd_en,
  input  logic [63:0] fifo_dout,
  output logic [23:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eol,
  output logic        frame_done,
  output logic        pad_err
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    cnt_reg, cnt_next;
  logic          rd_d_reg;
  logic [CW-1:0] col_reg, col_next;
  logic [CW-1:0] row_reg, row_next;
  logic          frame_done_reg, frame_done_next;
  logic          pad_err_reg, pad_err_next;

  logic          pop;
  logic          capture;
  logic          col_last;
  logic          row_last;
  logic [2:0]    occ_next;

  assign pop      = (cnt_reg != 2'd0) && m_ready;
  // A word arriving during clr belongs to the flushed stream and is dropped.
  assign capture  = rd_d_reg && !clr;
  assign col_last = (col_reg == COL_LAST);
  assign row_last = (row_reg == ROW_LAST);

  // Occupancy once the in-flight word lands and this cycle's pop retires.
  // Reading only when this is below 2 reserves a slot for every request, so
  // the two-entry buffer can never overflow. pop implies cnt_reg >= 1, so
  // the subtraction cannot underflow.
  assign occ_next = {1'b0, cnt_reg} + {2'b00, rd_d_reg} - {2'b00, pop};

  assign rd_en = rst_n && enable && !empty && !clr && (occ_next < 3'd2);

  // ---------------------------------------------------------------------
  // Two-entry skid buffer. Only the pixel bits are stored; the pad bits
  // are checked at capture time.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic [23:0] slot_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_reg <= '0;
      end else if (capture && (wr_ptr_reg == 1'(gi))) begin
        slot_reg <= fifo_dout[23:0];
      end
    end
  end

  assign m_data  = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
  assign m_valid = (cnt_reg != 2'd0);
  assign m_sof   = m_valid && (col_reg == '0) && (row_reg == '0);
  assign m_eol   = m_valid && col_last;

  assign frame_done = frame_done_reg;
  assign pad_err    = pad_err_reg;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = 2'd0;
    end else begin
      cnt_next = 2'(occ_next);
    end
  end

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (clr) begin
      col_next = '0;
      row_next = '0;
    end else if (pop) begin
      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : row_reg + CW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
    end
  end

  assign frame_done_next = !clr && pop && col_last && row_last;
  assign pad_err_next    = !clr && (pad_err_reg || (capture && (fifo_dout[63:24] != 40'd0)));

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      cnt_reg        <= 2'd0;
      rd_d_reg       <= 1'b0;
      col_reg        <= '0;
      row_reg        <= '0;
      frame_done_reg <= 1'b0;
      pad_err_reg    <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      rd_d_reg       <= rd_en;
      col_reg        <= col_next;
      row_reg        <= row_next;
      frame_done_reg <= frame_done_next;
      pad_err_reg    <= pad_err_next;
      if (clr) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
      end else begin
        if (capture) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)     rd_ptr_reg <= ~rd_ptr_reg;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Self-checking bench for fifo_pixel_reader with a 4x2 image. A small
// FIFO model with one cycle of read latency feeds the DUT, and a monitor
// records every accepted pixel.
module tb_fifo_pixel_reader;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int CW    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clr = 1'b0;
  logic        empty;
  logic        rd_en;
  logic [63:0] fifo_dout = '0;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_sof;
  logic        m_eol;
  logic        frame_done;
  logic        pad_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_pixel_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr(clr), .empty(empty),
    .rd_en(rd_en), .fifo_dout(fifo_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done),
    .pad_err(pad_err)
  );

  // FIFO source model
  logic [63:0] src_mem [0:511];
  int          wr_idx = 0;
  int          rd_idx = 0;
  logic        hold_empty = 1'b0;

  assign empty = hold_empty || (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (rd_en) begin
      fifo_dout <= src_mem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  // Monitor: records accepted pixels, frame_done pulses, stall stability
  logic [23:0] rx_data [0:511];
  logic        rx_sof  [0:511];
  logic        rx_eol  [0:511];
  int          rx_n = 0;
  int          fd_at [0:31];
  int          fd_n = 0;
  int          stall_viol = 0;
  int          empty_viol = 0;
  logic        prev_stall = 1'b0;
  logic        prev_clr = 1'b0;
  logic [23:0] prev_data = '0;
  logic        prev_sof = 1'b0;
  logic        prev_eol = 1'b0;

  always @(negedge clk) begin
    if (frame_done && fd_n < 32) begin
      fd_at[fd_n] = rx_n;
      fd_n++;
    end
    if (rd_en && empty) empty_viol++;
    if (rst_n && prev_stall && !prev_clr &&
        (!m_valid || m_data !== prev_data || m_sof !== prev_sof || m_eol !== prev_eol))
      stall_viol++;
    if (rst_n && m_valid && m_ready && rx_n < 512) begin
      rx_data[rx_n] = m_data;
      rx_sof[rx_n]  = m_sof;
      rx_eol[rx_n]  = m_eol;
      $display("pixel %0d data=%h sof=%b eol=%b", rx_n, m_data, m_sof, m_eol);
      rx_n++;
    end
    prev_stall = rst_n && m_valid && !m_ready;
    prev_clr   = clr;
    prev_data  = m_data;
    prev_sof   = m_sof;
    prev_eol   = m_eol;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] w);
    src_mem[wr_idx] = w;
    wr_idx++;
  endtask

  task automatic do_clr();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    push(64'h0000_0000_0055_AA11);
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data !== 24'h0) begin n_fail++; $display("FAIL reset_m_data: got %h want 000000", m_data); end
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
    n_checks++; if (m_sof !== 1'b0 || m_eol !== 1'b0) begin n_fail++; $display("FAIL reset_markers: got sof=%b eol=%b want 0 0", m_sof, m_eol); end
    n_checks++; if (frame_done !== 1'b0 || pad_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got fd=%b pad=%b want 0 0", frame_done, pad_err); end
    step();
    rst_n = 1'b1;
    repeat (6) step();
    n_checks++; if (rx_n !== 1) begin n_fail++; $display("FAIL reset_first_count: got %0d want 1", rx_n); end
    n_checks++; if (rx_data[0] !== 24'h55AA11 || rx_sof[0] !== 1'b1) begin n_fail++; $display("FAIL reset_first_pixel: got %h sof=%b want 55aa11 sof=1", rx_data[0], rx_sof[0]); end
    enable = 1'b0;
  endtask

  task automatic test_streaming();
    int base, first_rd, first_v, last_v, nvalid;
    do_clr();
    base = rx_n;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push({40'h0, 24'hAABB00 + 24'(i)});
    step();
    enable = 1'b1;
    first_rd = -1; first_v = -1; last_v = -1; nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rd_en && first_rd < 0) first_rd = c;
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        nvalid++;
      end
    end
    enable = 1'b0;
    n_checks++; if (first_v - first_rd !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", first_v - first_rd); end
    n_checks++; if (last_v - first_v + 1 !== 16 || nvalid !== 16) begin n_fail++; $display("FAIL stream_rate: got span=%0d valid=%0d want 16 16", last_v - first_v + 1, nvalid); end
    n_checks++; if (rx_n - base !== 16) begin n_fail++; $display("FAIL stream_count: got %0d want 16", rx_n - base); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rx_data[base+i] !== 24'hAABB00 + 24'(i)) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, rx_data[base+i], 24'hAABB00 + 24'(i));
      end
    end
    n_checks++; if (pad_err !== 1'b0) begin n_fail++; $display("FAIL stream_pad_err: got %b want 0", pad_err); end
  endtask

  task automatic test_framing();
    int base, fd_base;
    logic exp_sof, exp_eol;
    do_clr();
    base = rx_n;
    fd_base = fd_n;
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push({40'h0, 24'h100000 + 24'(i)});
    enable = 1'b1;
    repeat (30) step();
    enable = 1'b0;
    n_checks++; if (rx_n - base !== 16) begin n_fail++; $display("FAIL frame_count: got %0d want 16", rx_n - base); end
    for (int i = 0; i < 16; i++) begin
      exp_sof = (i == 0) || (i == 8);
      exp_eol = (i % 4) == 3;
      n_checks++;
      if (rx_sof[base+i] !== exp_sof || rx_eol[base+i] !== exp_eol) begin
        n_fail++; $display("FAIL frame_markers[%0d]: got sof=%b eol=%b want sof=%b eol=%b", i, rx_sof[base+i], rx_eol[base+i], exp_sof, exp_eol);
      end
    end
    n_checks++; if (fd_n - fd_base !== 2) begin n_fail++; $display("FAIL frame_done_count: got %0d want 2", fd_n - fd_base); end
    n_checks++; if (fd_at[fd_base] !== base + 8) begin n_fail++; $display("FAIL frame_done_first: got after %0d pixels want %0d", fd_at[fd_base] - base, 8); end
    n_checks++; if (fd_at[fd_base+1] !== base + 16) begin n_fail++; $display("FAIL frame_done_second: got after %0d pixels want %0d", fd_at[fd_base+1] - base, 16); end
  endtask

  task automatic test_backpressure();
    int base, sv0;
    do_clr();
    base = rx_n;
    sv0 = stall_viol;
    for (int i = 0; i < 100; i++) push({40'h0, 24'h300000 + 24'(i * 3)});
    enable = 1'b1;
    for (int c = 0; c < 1000 && (rx_n - base) < 100; c++) begin
      step();
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    repeat (4) step();
    enable = 1'b0;
    n_checks++; if (rx_n - base !== 100) begin n_fail++; $display("FAIL bp_count: got %0d want 100", rx_n - base); end
    for (int i = 0; i < 100; i++) begin
      n_checks++;
      if (rx_data[base+i] !== 24'h300000 + 24'(i * 3)) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx_data[base+i], 24'h300000 + 24'(i * 3));
      end
    end
    n_checks++; if (stall_viol !== sv0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_viol - sv0); end
  endtask

  task automatic test_empty_enable();
    int base;
    do_clr();
    base = rx_n;
    enable = 1'b0;
    m_ready = 1'b1;
    push({40'h0, 24'hDD0001});
    push({40'h0, 24'hDD0002});
    @(negedge clk);
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL ee_enable_low: got rd_en=%b want 0", rd_en); end
    step();
    enable = 1'b1;
    hold_empty = 1'b1;
    @(negedge clk);
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL ee_empty: got rd_en=%b want 0", rd_en); end
    step();
    hold_empty = 1'b0;
    @(negedge clk);
    n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL ee_issue: got rd_en=%b want 1", rd_en); end
    step();
    enable = 1'b0;
    @(negedge clk);
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL ee_dropped: got rd_en=%b want 0", rd_en); end
    repeat (5) step();
    n_checks++; if (rx_n - base !== 1 || rx_data[base] !== 24'hDD0001) begin n_fail++; $display("FAIL ee_inflight_kept: got count=%0d data=%h want 1 dd0001", rx_n - base, rx_data[base]); end
    enable = 1'b1;
    repeat (5) step();
    enable = 1'b0;
    n_checks++; if (rx_n - base !== 2 || rx_data[base+1] !== 24'hDD0002) begin n_fail++; $display("FAIL ee_resume: got count=%0d data=%h want 2 dd0002", rx_n - base, rx_data[base+1]); end
  endtask

  task automatic test_pad();
    int base;
    do_clr();
    base = rx_n;
    m_ready = 1'b1;
    push(64'h0000_0100_0012_3456);
    enable = 1'b1;
    repeat (5) step();
    n_checks++; if (rx_n - base !== 1 || rx_data[base] !== 24'h123456) begin n_fail++; $display("FAIL pad_data: got count=%0d data=%h want 1 123456", rx_n - base, rx_data[base]); end
    n_checks++; if (pad_err !== 1'b1) begin n_fail++; $display("FAIL pad_set: got %b want 1", pad_err); end
    push(64'h0000_0000_0000_0777);
    repeat (5) step();
    enable = 1'b0;
    n_checks++; if (rx_data[base+1] !== 24'h000777) begin n_fail++; $display("FAIL pad_clean_data: got %h want 000777", rx_data[base+1]); end
    n_checks++; if (pad_err !== 1'b1) begin n_fail++; $display("FAIL pad_sticky: got %b want 1", pad_err); end
    do_clr();
    @(negedge clk);
    n_checks++; if (pad_err !== 1'b0) begin n_fail++; $display("FAIL pad_cleared: got %b want 0", pad_err); end
  endtask

  task automatic test_clear();
    int base;
    logic got;
    do_clr();
    base = rx_n;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push({40'h0, 24'hC00000 + 24'(i)});
    enable = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      #1;
      if (rx_n - base >= 2) got = 1'b1;
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL clr_setup_timeout: got %0d pixels want 2", rx_n - base); end
    step();
    // Now at col 2: word 2 buffered, word 3 in flight.
    n_checks++; if (m_valid !== 1'b1 || m_data !== 24'hC00002) begin n_fail++; $display("FAIL clr_pre_state: got valid=%b data=%h want 1 c00002", m_valid, m_data); end
    clr = 1'b1;
    m_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL clr_rd_en: got %b want 0", rd_en); end
    step();
    clr = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", m_valid); end
    repeat (6) step();
    n_checks++; if (rx_data[base+2] !== 24'hC00004 || rx_sof[base+2] !== 1'b1) begin n_fail++; $display("FAIL clr_next_pixel: got %h sof=%b want c00004 sof=1", rx_data[base+2], rx_sof[base+2]); end
    repeat (6) step();
    enable = 1'b0;
    n_checks++; if (rx_n - base !== 6 || rx_data[base+5] !== 24'hC00007) begin n_fail++; $display("FAIL clr_drain: got count=%0d last=%h want 6 c00007", rx_n - base, rx_data[base+5]); end
  endtask

  task automatic test_async_reset();
    do_clr();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push({40'h0, 24'hE00001 + 24'(i)});
    enable = 1'b1;
    repeat (6) step();
    n_checks++; if (m_valid !== 1'b1 || rd_en !== 1'b0) begin n_fail++; $display("FAIL areset_pre: got valid=%b rd_en=%b want 1 0", m_valid, rd_en); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0 || m_data !== 24'h0) begin n_fail++; $display("FAIL areset_outputs: got valid=%b data=%h want 0 000000", m_valid, m_data); end
    n_checks++; if (rd_en !== 1'b0 || m_sof !== 1'b0 || m_eol !== 1'b0) begin n_fail++; $display("FAIL areset_strobes: got rd_en=%b sof=%b eol=%b want 0 0 0", rd_en, m_sof, m_eol); end
    n_checks++; if (frame_done !== 1'b0 || pad_err !== 1'b0) begin n_fail++; $display("FAIL areset_flags: got fd=%b pad=%b want 0 0", frame_done, pad_err); end
    enable = 1'b0;
    wr_idx = rd_idx;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_protocol();
    n_checks++; if (empty_viol !== 0) begin n_fail++; $display("FAIL rd_while_empty: got %0d reads want 0", empty_viol); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_framing();
    test_backpressure();
    test_empty_enable();
    test_pad();
    test_clear();
    test_async_reset();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
